// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and helpers for the multi-cycle ALU.
package alu_pkg;

  localparam logic [2:0] OP_FWD   = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_SHIFT = 3'b101;
  localparam logic [2:0] OP_SRA   = 3'b110;
  localparam logic [2:0] OP_ROR   = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    SHIFT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    IM_MUL = 3'd0,
    IM_SHL = 3'd1,
    IM_SHR = 3'd2,
    IM_SRA = 3'd3,
    IM_ROR = 3'd4
  } iter_mode_t;

  // Step counter must hold the value WIDTH itself (clamped shift count).
  function automatic int shamt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: one shift-add multiply step or one single-bit shift per cycle.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = shamt_width(WIDTH)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic               i_step,
  input  iter_mode_t         i_mode,
  input  logic [SHW-1:0]     i_count,
  input  logic [WIDTH-1:0]   i_opa,
  input  logic [WIDTH-1:0]   i_opb,
  output logic [2*WIDTH-1:0] o_next,
  output logic               o_last
);

  localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
  localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  iter_mode_t         r_mode;
  logic [SHW-1:0]     r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_next;
  logic               w_last;

  assign w_last = (r_cnt == CNT_ONE);

  // The multiplier's sign bit carries weight -2^(WIDTH-1), so the final step subtracts.
  always_comb begin
    w_next   = r_acc;
    w_addend = r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}};
    case (r_mode)
      IM_MUL: begin
        if (w_last) begin
          w_next = r_acc - w_addend;
        end else begin
          w_next = r_acc + w_addend;
        end
      end
      IM_SHL:  w_next = {{WIDTH{1'b0}}, r_acc[WIDTH-2:0], 1'b0};
      IM_SHR:  w_next = {{WIDTH{1'b0}}, 1'b0, r_acc[WIDTH-1:1]};
      IM_SRA:  w_next = {{WIDTH{1'b0}}, r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
      IM_ROR:  w_next = {{WIDTH{1'b0}}, r_acc[0], r_acc[WIDTH-1:1]};
      default: w_next = r_acc;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mode   <= IM_MUL;
      r_cnt    <= CNT_ZERO;
      r_acc    <= {(2*WIDTH){1'b0}};
      r_mcand  <= {(2*WIDTH){1'b0}};
      r_mplier <= {WIDTH{1'b0}};
    end else if (i_load) begin
      r_mode   <= i_mode;
      r_cnt    <= i_count;
      r_mcand  <= {{WIDTH{i_opa[WIDTH-1]}}, i_opa};
      r_mplier <= i_opb;
      r_acc    <= (i_mode == IM_MUL) ? {(2*WIDTH){1'b0}} : {{WIDTH{1'b0}}, i_opa};
    end else if (i_step && (r_cnt != CNT_ZERO)) begin
      r_acc    <= w_next;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_cnt    <= r_cnt - CNT_ONE;
    end
  end

  assign o_next = w_next;
  assign o_last = w_last;

endmodule

// File: rtl/alu_multicycle.sv
// Registered multi-cycle ALU with START/BUSY/DONE handshake; long ops run in alu_iter_unit.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_data1,
  input  logic [WIDTH-1:0] i_data2,
  input  logic [2:0]       i_select,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_ovf
);

  localparam int               SHW   = shamt_width(WIDTH);
  localparam int               LOG2W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_VEC = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   K_MAX = SHW'(WIDTH);

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_ovf;

  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_amt_shift;
  logic [WIDTH-1:0]   w_single;
  logic               w_single_ovf;
  logic               w_iter;
  iter_mode_t         w_mode;
  logic [SHW-1:0]     w_count;
  logic               w_load;
  logic               w_step;
  logic [2*WIDTH-1:0] w_next;
  logic               w_last;
  logic               w_mul_ovf;

  assign w_sum       = i_data1 + i_data2;
  assign w_amt_shift = {1'b0, i_data2[WIDTH-2:0]};

  // Decode: single-cycle result, or the mode and step count for the iterative unit.
  // A zero-length shift is finished at accept time, so its result is DATA1.
  always_comb begin
    w_single     = {WIDTH{1'b0}};
    w_single_ovf = 1'b0;
    w_iter       = 1'b0;
    w_mode       = IM_MUL;
    w_count      = {SHW{1'b0}};
    case (i_select)
      OP_FWD: w_single = i_data2;
      OP_ADD: begin
        w_single     = w_sum;
        w_single_ovf = (i_data1[WIDTH-1] == i_data2[WIDTH-1]) && (w_sum[WIDTH-1] != i_data1[WIDTH-1]);
      end
      OP_AND: w_single = i_data1 & i_data2;
      OP_OR:  w_single = i_data1 | i_data2;
      OP_MUL: begin
        w_iter  = 1'b1;
        w_mode  = IM_MUL;
        w_count = K_MAX;
      end
      OP_SHIFT: begin
        w_single = i_data1;
        w_mode   = i_data2[WIDTH-1] ? IM_SHR : IM_SHL;
        if (w_amt_shift >= W_VEC) begin
          w_count = K_MAX;
        end else begin
          w_count = w_amt_shift[SHW-1:0];
        end
        w_iter = (w_count != {SHW{1'b0}});
      end
      OP_SRA: begin
        w_single = i_data1;
        w_mode   = IM_SRA;
        if (i_data2 >= W_VEC) begin
          w_count = K_MAX;
        end else begin
          w_count = i_data2[SHW-1:0];
        end
        w_iter = (w_count != {SHW{1'b0}});
      end
      OP_ROR: begin
        w_single = i_data1;
        w_mode   = IM_ROR;
        w_count  = {1'b0, i_data2[LOG2W-1:0]};
        w_iter   = (w_count != {SHW{1'b0}});
      end
      default: w_single = {WIDTH{1'b0}};
    endcase
  end

  assign w_load    = (r_state == IDLE) && i_start && w_iter;
  assign w_step    = (r_state != IDLE);
  assign w_mul_ovf = (w_next[2*WIDTH-1:WIDTH] != {WIDTH{w_next[WIDTH-1]}});

  alu_iter_unit #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_mode  (w_mode),
    .i_count (w_count),
    .i_opa   (i_data1),
    .i_opb   (i_data2),
    .o_next  (w_next),
    .o_last  (w_last)
  );

  // Control FSM; the last iterative step writes the outputs and returns to IDLE on the same edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= {WIDTH{1'b0}};
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (w_iter) begin
              r_state <= (i_select == OP_MUL) ? MUL : SHIFT;
              r_busy  <= 1'b1;
            end else begin
              r_result <= w_single;
              r_zero   <= (w_single == {WIDTH{1'b0}});
              r_ovf    <= w_single_ovf;
              r_done   <= 1'b1;
            end
          end
        end
        MUL: begin
          if (w_last) begin
            r_result <= w_next[WIDTH-1:0];
            r_zero   <= (w_next[WIDTH-1:0] == {WIDTH{1'b0}});
            r_ovf    <= w_mul_ovf;
            r_done   <= 1'b1;
            r_state  <= IDLE;
            r_busy   <= 1'b0;
          end
        end
        SHIFT: begin
          if (w_last) begin
            r_result <= w_next[WIDTH-1:0];
            r_zero   <= (w_next[WIDTH-1:0] == {WIDTH{1'b0}});
            r_ovf    <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= IDLE;
            r_busy   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_zero   = r_zero;
  assign o_ovf    = r_ovf;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle (WIDTH=8) plus handshake/reset corner sequences.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] d1;
  logic [7:0] d2;
  logic [2:0] sel;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       zero;
  logic       ovf;

  int n_pass  = 0;
  int n_total = 0;

  alu_multicycle #(.WIDTH(8)) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_start  (start),
    .i_data1  (d1),
    .i_data2  (d2),
    .i_select (sel),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result),
    .o_zero   (zero),
    .o_ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       zero;
    logic       ovf;
    int         lat;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Issue one op and count negedges after the accept edge until DONE is seen (0 = timeout).
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic busy1);
    @(negedge clk);
    start = 1'b1; sel = op; d1 = a; d2 = b;
    lat   = 0;
    busy1 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) busy1 = busy;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    logic b1;
    int   dcount;

    vecs[0]  = '{OP_ADD,   8'h64, 8'h32, 8'h96, 1'b0, 1'b1, 1};
    vecs[1]  = '{OP_ADD,   8'h05, 8'hFB, 8'h00, 1'b1, 1'b0, 1};
    vecs[2]  = '{OP_MUL,   8'hFD, 8'h07, 8'hEB, 1'b0, 1'b0, 9};
    vecs[3]  = '{OP_MUL,   8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 9};
    vecs[4]  = '{OP_SRA,   8'h90, 8'h03, 8'hF2, 1'b0, 1'b0, 4};
    vecs[5]  = '{OP_SRA,   8'h90, 8'hC8, 8'hFF, 1'b0, 1'b0, 9};
    vecs[6]  = '{OP_ROR,   8'h81, 8'h09, 8'hC0, 1'b0, 1'b0, 2};
    vecs[7]  = '{OP_SHIFT, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0, 1};
    vecs[8]  = '{OP_SHIFT, 8'h80, 8'h82, 8'h20, 1'b0, 1'b0, 3};
    vecs[9]  = '{OP_AND,   8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1};
    vecs[10] = '{OP_OR,    8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 1};
    vecs[11] = '{OP_FWD,   8'h11, 8'h5A, 8'h5A, 1'b0, 1'b0, 1};
    vecs[12] = '{OP_SHIFT, 8'h03, 8'h02, 8'h0C, 1'b0, 1'b0, 3};
    vecs[13] = '{OP_MUL,   8'hF6, 8'hF4, 8'h78, 1'b0, 1'b0, 9};
    vecs[14] = '{OP_ROR,   8'h12, 8'h04, 8'h21, 1'b0, 1'b0, 5};
    vecs[15] = '{OP_ADD,   8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1};
    vecs[16] = '{OP_SHIFT, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 9};

    rst = 1'b1; start = 1'b0; d1 = 8'h00; d2 = 8'h00; sel = 3'b000;
    #2;
    check("reset_busy",   {31'd0, busy}, 32'd0);
    check("reset_done",   {31'd0, done}, 32'd0);
    check("reset_result", {24'd0, result}, 32'h0);
    check("reset_zero",   {31'd0, zero}, 32'd1);
    check("reset_ovf",    {31'd0, ovf},  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, b1);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_result", i), {24'd0, result}, {24'd0, vecs[i].res});
      check($sformatf("v%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].zero});
      check($sformatf("v%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
      check($sformatf("v%0d_busy", i), {31'd0, b1}, {31'd0, (vecs[i].lat > 1)});
    end

    // START while BUSY is ignored; START in the DONE cycle is accepted back-to-back.
    @(negedge clk);
    start = 1'b1; sel = OP_MUL; d1 = 8'hFD; d2 = 8'h07;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == 2);
      if (c == 1) begin d1 = 8'h10; d2 = 8'h10; end
      if (done) begin
        lat = c;
        break;
      end
    end
    check("busy_ignore_latency", lat, 9);
    check("busy_ignore_result", {24'd0, result}, 32'hEB);
    check("busy_ignore_ovf", {31'd0, ovf}, 32'd0);
    start = 1'b1; sel = OP_FWD; d2 = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done", {31'd0, done}, 32'd1);
    check("b2b_result", {24'd0, result}, 32'h5A);
    @(negedge clk);
    check("b2b_done_single_pulse", {31'd0, done}, 32'd0);
    check("b2b_idle", {31'd0, busy}, 32'd0);
    dcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("ignored_op_no_done", dcount, 0);
    check("result_held", {24'd0, result}, 32'h5A);

    // Reset mid-MUL discards the op.
    @(negedge clk);
    start = 1'b1; sel = OP_MUL; d1 = 8'h7F; d2 = 8'h03;
    @(negedge clk); start = 1'b0;
    check("mul_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy",   {31'd0, busy}, 32'd0);
    check("midrst_done",   {31'd0, done}, 32'd0);
    check("midrst_ovf",    {31'd0, ovf},  32'd0);
    check("midrst_result", {24'd0, result}, 32'h0);
    check("midrst_zero",   {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("midrst_no_done", dcount, 0);
    check("midrst_idle", {31'd0, busy}, 32'd0);

    run_op(OP_ADD, 8'h01, 8'h01, lat, b1);
    check("post_rst_latency", lat, 1);
    check("post_rst_result", {24'd0, result}, 32'h02);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
